// File: rtl/can_clic_arb.sv
// Registered priority arbiter for the CAN-CLIC interrupt controller.
// The top entry is the threshold; a source interrupts only by strictly beating it.
module can_clic_arb #(
    parameter  int N_ENTRIES = 4,
    parameter  int PRIO_W    = 3,
    localparam int IDX_W     = $clog2(N_ENTRIES)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_ENTRIES*PRIO_W-1:0] entries,
    output logic                        is_interrupt,
    output logic [IDX_W-1:0]            index
);

    localparam logic [IDX_W-1:0] THR_IDX = IDX_W'(N_ENTRIES - 1);

    logic [PRIO_W-1:0] win_val_s;
    logic [IDX_W-1:0]  win_idx_s;
    logic              is_interrupt_d;
    logic              is_interrupt_q;
    logic [IDX_W-1:0]  index_d;
    logic [IDX_W-1:0]  index_q;

    // Winner scan: ">=" lets the later (higher) index take ties, so the threshold wins ties.
    always_comb begin
        win_val_s = entries[0 +: PRIO_W];
        win_idx_s = {IDX_W{1'b0}};
        for (int k = 1; k < N_ENTRIES; k++) begin
            if (entries[k*PRIO_W +: PRIO_W] >= win_val_s) begin
                win_val_s = entries[k*PRIO_W +: PRIO_W];
                win_idx_s = IDX_W'(k);
            end else begin
                win_val_s = win_val_s;
                win_idx_s = win_idx_s;
            end
        end
    end

    // Next-state decision derived from the winner.
    always_comb begin
        is_interrupt_d = (win_idx_s != THR_IDX);
        index_d        = win_idx_s;
    end

    // Output registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            is_interrupt_q <= 1'b0;
            index_q        <= THR_IDX;
        end else begin
            is_interrupt_q <= is_interrupt_d;
            index_q        <= index_d;
        end
    end

    assign is_interrupt = is_interrupt_q;
    assign index        = index_q;

endmodule

// File: tb/tb_can_clic_arb.sv
// Self-checking bench for can_clic_arb: directed vectors plus randomized stream
// compared against a max-then-threshold reference model.
module tb_can_clic_arb;

    localparam int N  = 4;
    localparam int PW = 3;
    localparam int IW = $clog2(N);

    logic              clk;
    logic              reset;
    logic [N*PW-1:0]   entries;
    logic              is_interrupt;
    logic [IW-1:0]     index;

    int checks_n;
    int failures_n;

    can_clic_arb #(.N_ENTRIES(N), .PRIO_W(PW)) dut (
        .clk          (clk),
        .reset        (reset),
        .entries      (entries),
        .is_interrupt (is_interrupt),
        .index        (index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks_n++;
        if (obs != exp) begin
            failures_n++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: find the largest source value, take the highest source holding it,
    // and interrupt only if that value strictly exceeds the threshold.
    function automatic void model(input logic [N*PW-1:0] e, input bit rst,
                                  output int irq, output int idx);
        int vals[N];
        int mx;
        int thr;
        for (int k = 0; k < N; k++) vals[k] = int'((e >> (k*PW)) & ((1 << PW) - 1));
        thr = vals[N-1];
        mx  = 0;
        for (int k = 0; k < N-1; k++) if (vals[k] > mx) mx = vals[k];
        irq = 0;
        idx = N - 1;
        if (!rst && mx > thr) begin
            irq = 1;
            for (int k = 0; k < N-1; k++) if (vals[k] == mx) idx = k;
        end
    endfunction

    function automatic logic [N*PW-1:0] pack4(input int e3, input int e2, input int e1, input int e0);
        logic [PW-1:0] a, b, c, d;
        a = PW'(e3); b = PW'(e2); c = PW'(e1); d = PW'(e0);
        return {a, b, c, d};
    endfunction

    // Apply one vector for one cycle and check the outputs right after the edge.
    task automatic step(input string tag, input logic [N*PW-1:0] e, input bit rst);
        int irq_e, idx_e;
        @(negedge clk);
        entries = e;
        reset   = rst;
        model(e, rst, irq_e, idx_e);
        @(posedge clk);
        #1;
        check_val({tag, ".irq"}, int'(is_interrupt), irq_e);
        check_val({tag, ".idx"}, int'(index), idx_e);
    endtask

    initial begin
        logic [N*PW-1:0] e;
        checks_n   = 0;
        failures_n = 0;
        reset      = 1'b1;
        entries    = '0;

        step("rst0", pack4(0, 3, 2, 1), 1'b1);
        step("rst1", pack4(7, 0, 0, 0), 1'b1);

        step("thr_tie",  pack4(1, 0, 0, 1), 1'b0);
        step("all_zero", pack4(0, 0, 0, 0), 1'b0);
        step("win_a",    pack4(0, 3, 2, 1), 1'b0);
        step("win_b",    pack4(3, 5, 2, 6), 1'b0);
        step("win_c",    pack4(3, 5, 6, 4), 1'b0);
        step("src_tie",  pack4(2, 5, 5, 1), 1'b0);
        step("sat_thr",  pack4(7, 7, 7, 7), 1'b0);
        step("thr_zero", pack4(0, 0, 1, 0), 1'b0);
        step("tie_low",  pack4(1, 4, 0, 4), 1'b0);

        step("rst_hold0", pack4(0, 3, 2, 1), 1'b1);
        step("rst_hold1", pack4(0, 3, 2, 1), 1'b1);
        step("rst_rel",   pack4(0, 3, 2, 1), 1'b0);
        step("mid_a",     pack4(3, 5, 2, 6), 1'b0);
        step("mid_rst",   pack4(3, 5, 6, 4), 1'b1);
        step("mid_after", pack4(2, 5, 5, 1), 1'b0);

        for (int i = 0; i < 400; i++) begin
            e = N*PW'($urandom);
            case ($urandom_range(0, 7))
                0: e[N*PW-1 -: PW] = {PW{1'b0}};
                1: e[N*PW-1 -: PW] = {PW{1'b1}};
                default: e = e;
            endcase
            step("rand", e, ($urandom_range(0, 19) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
        $finish;
    end

endmodule
